// File: rtl/sma_moving_stats.sv
// sma_moving_stats
// Per-stock moving mean and variance over a BUFFER_SIZE-deep price window.
// Each update brings the price entering the window and the price leaving it.
// The block keeps a running sum, a running sum of squares and a fill count for
// every stock, and produces the stats through a three-stage pipeline.
//
// Ports:
//   i_clk, i_rst_n       clock, asynchronous active-low reset
//   i_valid              one update this cycle (no backpressure)
//   i_stock_id           stock being updated (ids >= NUM_STOCKS are dropped)
//   i_incoming_price     price entering the window
//   i_outgoing_price     price leaving the window (ignored during warm-up)
//   o_valid              one-cycle stats pulse, 3 cycles after i_valid
//   o_stock_id           stock the stats belong to
//   o_mean               floor(sum / BUFFER_SIZE)
//   o_variance           floor(sumsq / BUFFER_SIZE) - o_mean^2
//   o_window_full        the window for o_stock_id holds BUFFER_SIZE prices
module sma_moving_stats #(
  parameter int unsigned NUM_STOCKS  = 4,
  parameter int unsigned BUFFER_SIZE = 64,
  parameter int unsigned DATA_WIDTH  = 32,
  localparam int unsigned ID_W = (NUM_STOCKS > 1) ? $clog2(NUM_STOCKS) : 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_valid,
  input  logic [ID_W-1:0]         i_stock_id,
  input  logic [DATA_WIDTH-1:0]   i_incoming_price,
  input  logic [DATA_WIDTH-1:0]   i_outgoing_price,
  output logic                    o_valid,
  output logic [ID_W-1:0]         o_stock_id,
  output logic [DATA_WIDTH-1:0]   o_mean,
  output logic [2*DATA_WIDTH-1:0] o_variance,
  output logic                    o_window_full
);

  localparam int unsigned LOG2_BUF = $clog2(BUFFER_SIZE);
  localparam int unsigned SUM_W    = DATA_WIDTH + LOG2_BUF;
  localparam int unsigned SQ_W     = 2 * DATA_WIDTH;
  localparam int unsigned SUMSQ_W  = SQ_W + LOG2_BUF;
  localparam int unsigned CNT_W    = LOG2_BUF + 1;
  localparam int unsigned ID_SLOTS = 1 << ID_W;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BUFFER_SIZE);

  // Lookup of which encodable ids are real stocks; avoids a range compare that
  // is constant-true when NUM_STOCKS is a power of two.
  function automatic logic [ID_SLOTS-1:0] build_id_map();
    logic [ID_SLOTS-1:0] m;
    m = '0;
    for (int unsigned k = 0; k < ID_SLOTS; k++) m[k] = (k < NUM_STOCKS);
    return m;
  endfunction
  localparam logic [ID_SLOTS-1:0] ID_OK = build_id_map();

  // Per-stock accumulator state
  logic [SUM_W-1:0]   sum_mem   [NUM_STOCKS];
  logic [SUMSQ_W-1:0] sumsq_mem [NUM_STOCKS];
  logic [CNT_W-1:0]   cnt_mem   [NUM_STOCKS];

  // Stage 1 registers
  logic                  s1_valid;
  logic [ID_W-1:0]       s1_id;
  logic [DATA_WIDTH-1:0] s1_in;
  logic [DATA_WIDTH-1:0] s1_out;
  logic [SQ_W-1:0]       s1_in_sq;
  logic [SQ_W-1:0]       s1_out_sq;

  // Stage 2 registers
  logic                  s2_valid;
  logic [ID_W-1:0]       s2_id;
  logic [SUM_W-1:0]      s2_sum;
  logic [SUMSQ_W-1:0]    s2_sumsq;
  logic [CNT_W-1:0]      s2_cnt;

  // Stage 1 combinational
  logic                  accept;
  logic [CNT_W-1:0]      cnt_fwd;
  logic                  warm;
  logic [SQ_W-1:0]       in_sq;
  logic [SQ_W-1:0]       out_sq;

  always_comb begin
    accept  = i_valid & ID_OK[i_stock_id];
    cnt_fwd = cnt_mem[i_stock_id];
    // The update sitting in stage 1 writes its stock's count on this same
    // edge, so a following update to that stock must see the incremented value.
    if (s1_valid && (s1_id == i_stock_id)) begin
      cnt_fwd = (cnt_mem[s1_id] == FULL_CNT) ? FULL_CNT
                                             : cnt_mem[s1_id] + CNT_W'(1);
    end
    warm   = (cnt_fwd < FULL_CNT);
    in_sq  = SQ_W'(i_incoming_price) * SQ_W'(i_incoming_price);
    out_sq = SQ_W'(i_outgoing_price) * SQ_W'(i_outgoing_price);
  end

  // Stage 2 combinational: read-modify-write values
  logic [SUM_W-1:0]   sum_nxt;
  logic [SUMSQ_W-1:0] sumsq_nxt;
  logic [CNT_W-1:0]   cnt_nxt;

  always_comb begin
    // Modular arithmetic: an intermediate wrap of sum+in is undone by -out.
    sum_nxt   = sum_mem[s1_id] + SUM_W'(s1_in) - SUM_W'(s1_out);
    sumsq_nxt = sumsq_mem[s1_id] + SUMSQ_W'(s1_in_sq) - SUMSQ_W'(s1_out_sq);
    cnt_nxt   = (cnt_mem[s1_id] == FULL_CNT) ? FULL_CNT
                                             : cnt_mem[s1_id] + CNT_W'(1);
  end

  // Stage 3 combinational: mean and variance
  logic [DATA_WIDTH-1:0] mean_c;
  logic [SQ_W-1:0]       sq_div;
  logic [SQ_W-1:0]       mean_sq;
  logic [SQ_W-1:0]       var_c;
  logic                  full_c;

  always_comb begin
    mean_c  = DATA_WIDTH'(s2_sum >> LOG2_BUF);
    sq_div  = SQ_W'(s2_sumsq >> LOG2_BUF);
    mean_sq = SQ_W'(mean_c) * SQ_W'(mean_c);
    var_c   = (sq_div < mean_sq) ? '0 : (sq_div - mean_sq);
    full_c  = (s2_cnt == FULL_CNT);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned k = 0; k < NUM_STOCKS; k++) begin
        sum_mem[k]   <= '0;
        sumsq_mem[k] <= '0;
        cnt_mem[k]   <= '0;
      end
      s1_valid      <= 1'b0;
      s1_id         <= '0;
      s1_in         <= '0;
      s1_out        <= '0;
      s1_in_sq      <= '0;
      s1_out_sq     <= '0;
      s2_valid      <= 1'b0;
      s2_id         <= '0;
      s2_sum        <= '0;
      s2_sumsq      <= '0;
      s2_cnt        <= '0;
      o_valid       <= 1'b0;
      o_stock_id    <= '0;
      o_mean        <= '0;
      o_variance    <= '0;
      o_window_full <= 1'b0;
    end else begin
      // Stage 1: capture, square, gate the outgoing terms during warm-up
      s1_valid <= accept;
      if (accept) begin
        s1_id     <= i_stock_id;
        s1_in     <= i_incoming_price;
        s1_out    <= warm ? '0 : i_outgoing_price;
        s1_in_sq  <= in_sq;
        s1_out_sq <= warm ? '0 : out_sq;
      end

      // Stage 2: single-cycle accumulator update
      s2_valid <= s1_valid;
      if (s1_valid) begin
        sum_mem[s1_id]   <= sum_nxt;
        sumsq_mem[s1_id] <= sumsq_nxt;
        cnt_mem[s1_id]   <= cnt_nxt;
        s2_id            <= s1_id;
        s2_sum           <= sum_nxt;
        s2_sumsq         <= sumsq_nxt;
        s2_cnt           <= cnt_nxt;
      end

      // Stage 3: registered outputs
      o_valid <= s2_valid;
      if (s2_valid) begin
        o_stock_id    <= s2_id;
        o_mean        <= mean_c;
        o_variance    <= var_c;
        o_window_full <= full_c;
      end
    end
  end

endmodule

// File: tb/tb_sma_moving_stats.sv
// Testbench for sma_moving_stats (NUM_STOCKS=4, BUFFER_SIZE=4, DATA_WIDTH=32).
// Stimulus pushes expected stats into a queue computed from a per-stock price
// history; a monitor pops and compares on every o_valid pulse.
module tb_sma_moving_stats;

  localparam int unsigned NS = 4;
  localparam int unsigned B  = 4;
  localparam int unsigned DW = 32;

  logic          i_clk = 1'b0;
  logic          i_rst_n;
  logic          i_valid;
  logic [1:0]    i_stock_id;
  logic [DW-1:0] i_incoming_price;
  logic [DW-1:0] i_outgoing_price;
  logic          o_valid;
  logic [1:0]    o_stock_id;
  logic [DW-1:0] o_mean;
  logic [2*DW-1:0] o_variance;
  logic          o_window_full;

  sma_moving_stats #(
    .NUM_STOCKS (NS),
    .BUFFER_SIZE(B),
    .DATA_WIDTH (DW)
  ) dut (
    .i_clk           (i_clk),
    .i_rst_n         (i_rst_n),
    .i_valid         (i_valid),
    .i_stock_id      (i_stock_id),
    .i_incoming_price(i_incoming_price),
    .i_outgoing_price(i_outgoing_price),
    .o_valid         (o_valid),
    .o_stock_id      (o_stock_id),
    .o_mean          (o_mean),
    .o_variance      (o_variance),
    .o_window_full   (o_window_full)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [1:0]      id;
    logic [DW-1:0]   mean;
    logic [2*DW-1:0] variance;
    logic            full;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned hist[NS][$];
  int          compared   = 0;
  int          mismatched = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, req, req, $time);
    end
  endtask

  // Reference: stats straight from the last min(n, B) prices of the history.
  function automatic exp_t model_push(input int unsigned id, input int unsigned p);
    exp_t e;
    logic [127:0] s, sq, m;
    int n, k;
    hist[id].push_back(p);
    n = hist[id].size();
    k = (n < B) ? n : B;
    s = '0;
    sq = '0;
    for (int j = n - k; j < n; j++) begin
      s  += 128'(hist[id][j]);
      sq += 128'(hist[id][j]) * 128'(hist[id][j]);
    end
    m = s / B;
    e.id       = 2'(id);
    e.mean     = DW'(m);
    e.variance = 64'(sq / B - m * m);
    e.full     = (n >= B);
    return e;
  endfunction

  task automatic issue(input int unsigned id, input int unsigned p, input int unsigned garbage);
    int unsigned out_p;
    int n;
    n = hist[id].size();
    out_p = (n >= B) ? hist[id][n - B] : garbage;
    exp_q.push_back(model_push(id, p));
    i_valid          = 1'b1;
    i_stock_id       = 2'(id);
    i_incoming_price = p;
    i_outgoing_price = out_p;
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
  endtask

  task automatic idle(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  // Asynchronous reset asserted away from any edge; in-flight work is discarded.
  task automatic do_reset();
    #2;
    i_rst_n = 1'b0;
    exp_q.delete();
    for (int s = 0; s < NS; s++) hist[s].delete();
    #1;
    check("rst_o_valid", 64'(o_valid), 64'd0);
    check("rst_o_stock_id", 64'(o_stock_id), 64'd0);
    check("rst_o_mean", 64'(o_mean), 64'd0);
    check("rst_o_variance", o_variance, 64'd0);
    check("rst_o_window_full", 64'(o_window_full), 64'd0);
    idle(2);
    #2;
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;
  endtask

  task automatic drain();
    for (int c = 0; c < 20 && exp_q.size() != 0; c++) begin
      @(posedge i_clk);
      #1;
    end
    check("drain_pending", 64'(exp_q.size()), 64'd0);
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge i_clk);
      if (i_rst_n && o_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_o_valid", 64'(o_valid), 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("o_stock_id", 64'(o_stock_id), 64'(e.id));
          check("o_mean", 64'(o_mean), 64'(e.mean));
          check("o_variance", o_variance, e.variance);
          check("o_window_full", 64'(o_window_full), 64'(e.full));
        end
      end
    end
  end

  initial begin
    i_rst_n          = 1'b0;
    i_valid          = 1'b0;
    i_stock_id       = '0;
    i_incoming_price = '0;
    i_outgoing_price = '0;
    idle(3);
    #2;
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;

    // First update after reset: count starts at 1
    issue(3, 8, 32'hDEADBEEF);
    drain();

    // Reset with two updates in flight: no o_valid for them, state restarts
    issue(1, 1000, 32'h12345678);
    issue(1, 2000, 32'h12345678);
    do_reset();
    for (int c = 0; c < 5; c++) begin
      check("post_rst_no_valid", 64'(o_valid), 64'd0);
      idle(1);
    end
    issue(1, 40, 32'hDEADBEEF);
    drain();
    do_reset();

    // Warm-up then steady state on stock 0
    issue(0, 10, 32'hDEADBEEF);
    issue(0, 20, 32'hDEADBEEF);
    issue(0, 30, 32'hDEADBEEF);
    issue(0, 40, 32'hDEADBEEF);
    issue(0, 50, 32'hDEADBEEF);

    // Interleaved stocks 1 and 2, then stock 0 again
    for (int r = 0; r < 4; r++) begin
      issue(1, 100, 32'hDEADBEEF);
      issue(2, 7, 32'hDEADBEEF);
    end
    issue(0, 60, 32'hDEADBEEF);

    // Back-to-back across the warm-up boundary on stock 3
    issue(3, 11, 32'hFFFFFFFF);
    issue(3, 22, 32'hFFFFFFFF);
    issue(3, 33, 32'hFFFFFFFF);
    issue(3, 44, 32'hFFFFFFFF);
    issue(3, 55, 32'hFFFFFFFF);
    issue(3, 66, 32'hFFFFFFFF);
    drain();

    // Same sequence spaced out on a fresh stock 3
    do_reset();
    for (int j = 1; j <= 6; j++) begin
      issue(3, 11 * j, 32'hFFFFFFFF);
      idle(4);
    end
    drain();

    // Randomized traffic, often concentrated on few stocks to stress forwarding
    for (int it = 0; it < 600; it++) begin
      int unsigned id, p;
      if ($urandom_range(0, 3) == 0) begin
        idle(1);
      end else begin
        id = (it < 300) ? $urandom_range(0, 1) : $urandom_range(0, NS - 1);
        p  = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 1000) : $urandom;
        issue(id, p, $urandom);
      end
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/sma_moving_stats.md
Name: sma_moving_stats

Overview:
- Downstream consumer of the per-stock SMA price buffer memory.
- Each update carries the newly written (incoming) price and the overwritten (outgoing) price for one stock.
- The block maintains per-stock running sum, running sum of squares and window fill count, and emits the moving mean and variance for that stock.
- Outputs feed the strategy/signal stage.

Parameters:
- NUM_STOCKS, 4: number of independent stock windows.
- BUFFER_SIZE, 64: window length per stock. Must be a power of two; division is a right shift by LOG2_BUF = $clog2(BUFFER_SIZE).
- DATA_WIDTH, 32: unsigned price width.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_valid  in  1  one update this cycle.
- i_stock_id  in  $clog2(NUM_STOCKS)  stock being updated.
- i_incoming_price  in  DATA_WIDTH  price entering the window.
- i_outgoing_price  in  DATA_WIDTH  price leaving the window. Contents are undefined during warm-up.
- o_valid  out  1  stats valid, one-cycle pulse per update.
- o_stock_id  out  $clog2(NUM_STOCKS)  stock the stats belong to.
- o_mean  out  DATA_WIDTH  floor(sum / BUFFER_SIZE).
- o_variance  out  2*DATA_WIDTH  floor(sumsq / BUFFER_SIZE) - o_mean².
- o_window_full  out  1  window for o_stock_id has held BUFFER_SIZE prices.

Behaviour:
- Reset is asynchronous and active-low, and clears:
  - all per-stock sum, sumsq and count registers;
  - all pipeline valid bits;
  - all outputs (o_valid, o_stock_id, o_mean, o_variance, o_window_full all 0).
- Input alignment: i_incoming_price and i_outgoing_price are aligned by the upstream stage and presented together with i_valid. No backpressure; one update may be accepted every cycle.
- Pipeline is 3 stages; latency is exactly 3 cycles from i_valid to o_valid.
  - S1: register stock_id, incoming and outgoing prices. Compute incoming² and outgoing² (2*DATA_WIDTH each). Force the outgoing terms to 0 if count[id] < BUFFER_SIZE (warm-up gating).
  - S2: single-cycle read-modify-write of the per-stock arrays.
    - sum[id] += in - out_g, width DATA_WIDTH+LOG2_BUF.
    - sumsq[id] += in² - out_g², width 2*DATA_WIDTH+LOG2_BUF.
    - count[id] saturating increment at BUFFER_SIZE.
    - Register the updated values for S3.
  - S3: mean = sum >> LOG2_BUF, truncated to DATA_WIDTH. var = (sumsq >> LOG2_BUF) - mean*mean, clamped to 0 if negative (cannot occur mathematically; the clamp is a guard). window_full = (updated count == BUFFER_SIZE). Register all outputs.
- Warm-up: the count check in S1 must use the value that includes any update to the same stock currently in S2 (forward it). Otherwise the BUFFER_SIZE-th and (BUFFER_SIZE+1)-th back-to-back updates gate incorrectly.
- Hazards: the accumulator RMW completes in one cycle (S2), so back-to-back updates to the same stock need no stall. Each sees the prior result.
- During warm-up, mean and variance are still computed with the fixed divisor BUFFER_SIZE. Consumers qualify them with o_window_full.
- Arithmetic is unsigned throughout. The sum never underflows, because out_g was previously added.
- o_valid deasserts the cycle after each pulse unless another update follows.
- Reset mid-operation discards in-flight updates; no o_valid is produced for them.
- Out-of-range i_stock_id (≥ NUM_STOCKS) with i_valid: the update is dropped, with no state change and no o_valid.

Test Plan:
(Test parameters: BUFFER_SIZE=4, NUM_STOCKS=4, DATA_WIDTH=32.)
1. Assert i_rst_n=0 asynchronously mid-clock -> all outputs 0 immediately. First update after release gives count 1.
2. Warm-up, stock 0: incoming 10, 20, 30, 40 on consecutive cycles, outgoing 0xDEADBEEF -> o_mean 2, 7, 15, 25 on cycles 3 to 6. 4th update: o_variance 750-625=125, o_window_full 0,0,0,1.
3. Steady state, stock 0: incoming 50, outgoing 10 -> sum 140, o_mean 35, sumsq 5400, o_variance 1350-1225=125, o_window_full 1.
4. Interleave stock 1 (price 100 ×4) and stock 2 (price 7 ×4) every cycle -> stock 1 mean 100, var 0. Stock 2 mean 7, var 0. Stock 0 state unchanged.
5. Same stock on consecutive cycles across the warm-up boundary (5 updates, 5th outgoing = 1st price) -> stats identical to the spaced-out sequence. Verifies RMW and count forwarding.
6. Drop i_rst_n while two updates are in flight -> no o_valid for them. Accumulators restart from 0.
